// File: rtl/tx_ctrl_pkg.sv
// Shared types and constants for the serial transmit sequencer.
// Line levels and frame geometry live here so datapath and FSM agree.
package tx_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   localparam int DATA_BITS = 8;

endpackage

// File: rtl/shift_reg8.sv
// 8-bit parallel-load, right-shift register for the transmit datapath.
// Exposes the LSB and the bit that becomes LSB after the next shift.
module shift_reg8 (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic       enable,
   input  logic [7:0] din,
   output logic       lsb,
   output logic       nxt
);

   logic [7:0] q;

   always_ff @(posedge clock) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (enable) begin
         q <= {1'b0, q[7:1]};
      end
   end

   assign lsb = q[0];
   assign nxt = q[1];

endmodule

// File: rtl/tx_frame_controller.sv
// Frame sequencer: start, 8 data bits LSB-first, optional parity, stop.
// Every non-idle state lasts DIV clocks; all outputs are registered.
module tx_frame_controller
   import tx_ctrl_pkg::*;
#(
   parameter int DIV        = 4,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       req,
   output logic       ack,
   output logic       busy,
   output logic       serial_out,
   output logic       done,
   output logic       sh_load,
   output logic       sh_enable,
   output logic [3:0] bit_cnt
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   state_e        state;
   logic [CW-1:0] cnt;
   logic          par;
   logic          accept;
   logic          last;
   logic          shift;
   logic          sr_lsb;
   logic          sr_nxt;

   assign accept = (state == IDLE) && req;
   assign last   = (cnt == LAST);
   assign shift  = (state == DATA) && last;

   // The register moves on the same edge the strobes are issued,
   // so the next line bit is always available as sr_nxt.
   shift_reg8 u_sr (
      .clock  (clock),
      .reset  (reset),
      .load   (accept),
      .enable (shift),
      .din    (data_in),
      .lsb    (sr_lsb),
      .nxt    (sr_nxt)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         par        <= 1'b0;
         ack        <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
         sh_load    <= 1'b0;
         sh_enable  <= 1'b0;
         bit_cnt    <= '0;
         serial_out <= IDLE_LEVEL;
      end else begin
         ack       <= accept;
         sh_load   <= accept;
         sh_enable <= shift;
         done      <= 1'b0;
         if (state != IDLE) begin
            cnt <= last ? '0 : cnt + CW'(1);
         end
         unique case (state)
            IDLE: begin
               if (req) begin
                  state      <= START;
                  cnt        <= '0;
                  busy       <= 1'b1;
                  par        <= (^data_in) ^ PARITY_ODD;
                  serial_out <= START_LEVEL;
               end
            end
            START: begin
               if (last) begin
                  state      <= DATA;
                  serial_out <= sr_lsb;
               end
            end
            DATA: begin
               if (last) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'(DATA_BITS - 1)) begin
                     if (PARITY_EN) begin
                        state      <= PARITY;
                        serial_out <= par;
                     end else begin
                        state      <= STOP;
                        serial_out <= STOP_LEVEL;
                     end
                  end else begin
                     serial_out <= sr_nxt;
                  end
               end
            end
            PARITY: begin
               if (last) begin
                  state      <= STOP;
                  serial_out <= STOP_LEVEL;
               end
            end
            STOP: begin
               if (last) begin
                  state      <= IDLE;
                  done       <= 1'b1;
                  busy       <= 1'b0;
                  bit_cnt    <= '0;
                  serial_out <= IDLE_LEVEL;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_frame_controller.sv
// Directed bench for tx_frame_controller: four parameterisations
// share req/data_in; every output is captured per cycle and checked.
module tb_tx_frame_controller;

   localparam int NCAP = 96;

   logic       clock = 1'b0;
   logic       reset;
   logic       req;
   logic [7:0] data_in;

   logic       so [4];
   logic       ak [4];
   logic       dn [4];
   logic       by [4];
   logic       ld [4];
   logic       en [4];
   logic [3:0] bc [4];

   logic       c_so [4][NCAP+1];
   logic       c_ak [4][NCAP+1];
   logic       c_dn [4][NCAP+1];
   logic       c_by [4][NCAP+1];
   logic       c_ld [4][NCAP+1];
   logic       c_en [4][NCAP+1];
   logic [3:0] c_bc [4][NCAP+1];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   tx_frame_controller #(.DIV(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
      .clock(clock), .reset(reset), .data_in(data_in), .req(req),
      .ack(ak[0]), .busy(by[0]), .serial_out(so[0]), .done(dn[0]),
      .sh_load(ld[0]), .sh_enable(en[0]), .bit_cnt(bc[0]));

   tx_frame_controller #(.DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
      .clock(clock), .reset(reset), .data_in(data_in), .req(req),
      .ack(ak[1]), .busy(by[1]), .serial_out(so[1]), .done(dn[1]),
      .sh_load(ld[1]), .sh_enable(en[1]), .bit_cnt(bc[1]));

   tx_frame_controller #(.DIV(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (
      .clock(clock), .reset(reset), .data_in(data_in), .req(req),
      .ack(ak[2]), .busy(by[2]), .serial_out(so[2]), .done(dn[2]),
      .sh_load(ld[2]), .sh_enable(en[2]), .bit_cnt(bc[2]));

   tx_frame_controller #(.DIV(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u3 (
      .clock(clock), .reset(reset), .data_in(data_in), .req(req),
      .ack(ak[3]), .busy(by[3]), .serial_out(so[3]), .done(dn[3]),
      .sh_load(ld[3]), .sh_enable(en[3]), .bit_cnt(bc[3]));

   // Expected line level t cycles after acceptance (t=1 is first low).
   function automatic logic exp_line(input logic [7:0] b, input int d,
                                     input bit pe, input bit po,
                                     input int t);
      int i;
      if (t < 1) return 1'b1;
      i = (t - 1) / d;
      if (i == 0) return 1'b0;
      if (i <= 8) return b[i-1];
      if (pe && i == 9) return (^b) ^ po;
      return 1'b1;
   endfunction

   function automatic int line_errs(input int k, input logic [7:0] b,
                                    input int d, input bit pe,
                                    input bit po, input int t0,
                                    input int t1, input int off);
      int n = 0;
      for (int t = t0; t <= t1; t++)
         if (c_so[k][t] !== exp_line(b, d, pe, po, t - off)) n++;
      return n;
   endfunction

   function automatic int first_done(input int k, input int from);
      for (int t = from; t <= NCAP; t++)
         if (c_dn[k][t] === 1'b1) return t;
      return -1;
   endfunction

   function automatic int n_ack(input int k);
      int n = 0;
      for (int t = 1; t <= NCAP; t++) if (c_ak[k][t] === 1'b1) n++;
      return n;
   endfunction

   function automatic int n_en(input int k, input int t1);
      int n = 0;
      for (int t = 1; t <= t1; t++) if (c_en[k][t] === 1'b1) n++;
      return n;
   endfunction

   function automatic int n_done(input int k);
      int n = 0;
      for (int t = 1; t <= NCAP; t++) if (c_dn[k][t] === 1'b1) n++;
      return n;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Raise req with byte b, capture NCAP cycles of every instance.
   task automatic run_frame(input logic [7:0] b, input logic [7:0] b2,
                            input int hold_t, input int inj_t,
                            input int rst_t);
      data_in = b;
      req     = 1'b1;
      for (int t = 1; t <= NCAP; t++) begin
         @(posedge clock);
         #1;
         for (int k = 0; k < 4; k++) begin
            c_so[k][t] = so[k];
            c_ak[k][t] = ak[k];
            c_dn[k][t] = dn[k];
            c_by[k][t] = by[k];
            c_ld[k][t] = ld[k];
            c_en[k][t] = en[k];
            c_bc[k][t] = bc[k];
         end
         if (t == 1) data_in = b2;
         if (t == hold_t) req = 1'b0;
         if (inj_t > 0 && t == inj_t) begin
            req     = 1'b1;
            data_in = 8'hFF;
         end
         if (inj_t > 0 && t == inj_t + 3) req = 1'b0;
         if (rst_t > 0 && t == rst_t) reset = 1'b1;
         if (rst_t > 0 && t == rst_t + 1) reset = 1'b0;
      end
      req     = 1'b0;
      data_in = 8'h00;
   endtask

   task automatic test_reset;
      logic [9:0] obs;
      reset   = 1'b1;
      req     = 1'b0;
      data_in = 8'h00;
      idle(2);
      for (int k = 0; k < 4; k++) begin
         obs = {so[k], ak[k], by[k], dn[k], ld[k], en[k], bc[k]};
         vectors++;
         if (obs !== 10'b10_0000_0000) begin
            miscompares++;
            $display("FAIL reset_state u%0d got %b want %b",
                     k, obs, 10'b10_0000_0000);
         end
      end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_frame;
      int v;
      idle(4);
      run_frame(8'hB2, 8'hB2, 1, 0, 0);
      v = {28'd0, c_ak[0][1], c_so[0][1], c_ld[0][1], c_by[0][1]};
      vectors++;
      if (v !== 4'b1011) begin
         miscompares++;
         $display("FAIL accept_cycle got %b want 1011", v[3:0]);
      end
      v = line_errs(0, 8'hB2, 4, 0, 0, 1, 41, 0);
      vectors++;
      if (v !== 0) begin
         miscompares++;
         $display("FAIL line_b2 got %0d bad cycles want 0", v);
      end
      v = first_done(0, 1);
      vectors++;
      if (v !== 41 || n_done(0) !== 1) begin
         miscompares++;
         $display("FAIL done_41 got t=%0d n=%0d want t=41 n=1",
                  v, n_done(0));
      end
      vectors++;
      if (n_ack(0) !== 1) begin
         miscompares++;
         $display("FAIL ack_count got %0d want 1", n_ack(0));
      end
      vectors++;
      if (n_en(0, NCAP) !== 8) begin
         miscompares++;
         $display("FAIL shift_pulses got %0d want 8", n_en(0, NCAP));
      end
      vectors++;
      if (c_bc[0][37] !== 4'd8 || c_bc[0][41] !== 4'd0) begin
         miscompares++;
         $display("FAIL bit_cnt_end got %0d/%0d want 8/0",
                  c_bc[0][37], c_bc[0][41]);
      end
      vectors++;
      if ({c_by[0][40], c_by[0][41]} !== 2'b10) begin
         miscompares++;
         $display("FAIL busy_clear got %b want 10",
                  {c_by[0][40], c_by[0][41]});
      end
      v = line_errs(1, 8'hB2, 4, 1, 0, 1, 45, 0);
      vectors++;
      if (v !== 0 || c_so[1][38] !== 1'b0) begin
         miscompares++;
         $display("FAIL even_par_b2 got %0d bad, par=%b want 0 bad par=0",
                  v, c_so[1][38]);
      end
      v = first_done(1, 1);
      vectors++;
      if (v !== 45) begin
         miscompares++;
         $display("FAIL par_done_45 got %0d want 45", v);
      end
   endtask

   task automatic test_parity;
      int v;
      idle(4);
      run_frame(8'h0B, 8'h0B, 1, 0, 0);
      v = line_errs(1, 8'h0B, 4, 1, 0, 1, 45, 0);
      vectors++;
      if (v !== 0 || c_so[1][38] !== 1'b1) begin
         miscompares++;
         $display("FAIL even_par_0b got %0d bad, par=%b want 0 bad par=1",
                  v, c_so[1][38]);
      end
      v = line_errs(2, 8'h0B, 4, 1, 1, 1, 45, 0);
      vectors++;
      if (v !== 0 || c_so[2][38] !== 1'b0) begin
         miscompares++;
         $display("FAIL odd_par_0b got %0d bad, par=%b want 0 bad par=0",
                  v, c_so[2][38]);
      end
      vectors++;
      if (first_done(2, 1) !== 45) begin
         miscompares++;
         $display("FAIL odd_done_45 got %0d want 45", first_done(2, 1));
      end
   endtask

   task automatic test_back_to_back;
      int v;
      idle(4);
      run_frame(8'hB2, 8'h0B, 42, 0, 0);
      vectors++;
      if (c_dn[0][41] !== 1'b1 || c_ak[0][42] !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_ack got done41=%b ack42=%b want 1 1",
                  c_dn[0][41], c_ak[0][42]);
      end
      v = {29'd0, c_by[0][40], c_by[0][41], c_by[0][42]};
      vectors++;
      if (v !== 3'b101 || c_so[0][41] !== 1'b1 || c_so[0][42] !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_gap got busy=%b line41=%b line42=%b want 101 1 0",
                  v[2:0], c_so[0][41], c_so[0][42]);
      end
      v = line_errs(0, 8'h0B, 4, 0, 0, 42, 82, 41);
      vectors++;
      if (v !== 0) begin
         miscompares++;
         $display("FAIL b2b_line2 got %0d bad cycles want 0", v);
      end
      vectors++;
      if (n_ack(0) !== 2 || first_done(0, 42) !== 82) begin
         miscompares++;
         $display("FAIL b2b_done2 got acks=%0d done=%0d want 2 82",
                  n_ack(0), first_done(0, 42));
      end
   endtask

   task automatic test_busy_ignore;
      int v;
      idle(4);
      run_frame(8'hB2, 8'hB2, 1, 14, 0);
      vectors++;
      if (n_ack(0) !== 1) begin
         miscompares++;
         $display("FAIL busy_req_ack got %0d want 1", n_ack(0));
      end
      v = line_errs(0, 8'hB2, 4, 0, 0, 1, 41, 0);
      vectors++;
      if (v !== 0 || first_done(0, 1) !== 41) begin
         miscompares++;
         $display("FAIL busy_req_line got %0d bad done=%0d want 0 41",
                  v, first_done(0, 1));
      end
   endtask

   task automatic test_reset_mid;
      int v;
      idle(4);
      run_frame(8'hB2, 8'hB2, 1, 0, 18);
      vectors++;
      if (c_bc[0][18] !== 4'd3) begin
         miscompares++;
         $display("FAIL pre_reset_cnt got %0d want 3", c_bc[0][18]);
      end
      v = {27'd0, c_so[0][19], c_by[0][19], c_bc[0][19]};
      vectors++;
      if (v !== 6'b10_0000) begin
         miscompares++;
         $display("FAIL mid_reset got %b want 100000", v[5:0]);
      end
      vectors++;
      if (n_done(0) !== 0) begin
         miscompares++;
         $display("FAIL reset_no_done got %0d want 0", n_done(0));
      end
      idle(2);
      run_frame(8'hB2, 8'hB2, 1, 0, 0);
      v = line_errs(0, 8'hB2, 4, 0, 0, 1, 41, 0);
      vectors++;
      if (v !== 0 || first_done(0, 1) !== 41) begin
         miscompares++;
         $display("FAIL post_reset_frame got %0d bad done=%0d want 0 41",
                  v, first_done(0, 1));
      end
   endtask

   task automatic test_div1;
      logic [9:0] line;
      idle(4);
      run_frame(8'h01, 8'h01, 1, 0, 0);
      for (int t = 1; t <= 10; t++) line[10-t] = c_so[3][t];
      vectors++;
      if (line !== 10'b0100000001) begin
         miscompares++;
         $display("FAIL div1_line got %b want 0100000001", line);
      end
      vectors++;
      if (first_done(3, 1) !== 11 || n_en(3, 11) !== 8) begin
         miscompares++;
         $display("FAIL div1_done got t=%0d en=%0d want 11 8",
                  first_done(3, 1), n_en(3, 11));
      end
   endtask

   initial begin
      test_reset;
      test_frame;
      test_parity;
      test_back_to_back;
      test_busy_ignore;
      test_reset_mid;
      test_div1;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
